// File: rtl/nco_pkg.sv
// Constants and types shared by the LUT NCO and its receive-side frequency meter.
package nco_pkg;

    localparam int SAMPLE_WIDTH              = 16;
    localparam int ACC_SIZE                  = 10;
    localparam int PHASE_BITWIDTH_FRACTIONAL = 4;
    localparam int PERIODS_LOG2              = 2;
    localparam int CNT_WIDTH                 = 16;
    localparam int HYST                      = 256;

    localparam logic [ACC_SIZE-1:0] STEP_MAX = ACC_SIZE'((1 << (ACC_SIZE - 1)) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/nco_freq_meter_if.sv
// Sample-in / step-out bus of the frequency meter, qualified by the active-low chip select.
interface nco_freq_meter_if #(
    parameter int SAMPLE_WIDTH = nco_pkg::SAMPLE_WIDTH,
    parameter int ACC_SIZE     = nco_pkg::ACC_SIZE
) ();

    logic                           inCS;
    logic signed [SAMPLE_WIDTH-1:0] sample;
    logic signed [ACC_SIZE-1:0]     step_est;
    logic                           valid;
    logic                           timeout;
    logic                           busy;

    modport master (output inCS, output sample,
                    input  step_est, input valid, input timeout, input busy);

    modport slave  (input  inCS, input sample,
                    output step_est, output valid, output timeout, output busy);

endinterface

// File: rtl/nco_step_divider.sv
// Restoring divider: 2^(ACC_SIZE+PERIODS_LOG2) / divisor, one quotient bit per enabled cycle,
// followed by a register stage that saturates to the largest sub-Nyquist step.
module nco_step_divider #(
    parameter int ACC_SIZE     = nco_pkg::ACC_SIZE,
    parameter int PERIODS_LOG2 = nco_pkg::PERIODS_LOG2,
    parameter int CNT_WIDTH    = nco_pkg::CNT_WIDTH
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ACC_SIZE-1:0]  o_quotient
);

    localparam int QW = ACC_SIZE + PERIODS_LOG2 + 1;
    localparam int IW = $clog2(QW);
    localparam logic [QW-1:0]       SAT_LIMIT = QW'(1) << (ACC_SIZE - 1);
    localparam logic [ACC_SIZE-1:0] SAT_VALUE = ACC_SIZE'((1 << (ACC_SIZE - 1)) - 1);

    logic [CNT_WIDTH-1:0] r_divisor;
    logic [CNT_WIDTH-1:0] r_rem;
    logic [QW-1:0]        r_quo;
    logic [IW-1:0]        r_iter;
    logic                 r_busy;
    logic                 r_fin;
    logic                 r_done;
    logic [ACC_SIZE-1:0]  r_quotient;

    logic                 w_bit;
    logic [CNT_WIDTH:0]   w_trial;
    logic [CNT_WIDTH:0]   w_diff;
    logic                 w_ge;
    logic [ACC_SIZE-1:0]  w_sat;

    // The numerator is a single power of two, so only the first iteration shifts in a 1.
    assign w_bit   = (r_iter == IW'(0));
    assign w_trial = {r_rem, w_bit};
    assign w_diff  = w_trial - {1'b0, r_divisor};
    assign w_ge    = (w_trial >= {1'b0, r_divisor});
    assign w_sat   = (r_quo >= SAT_LIMIT) ? SAT_VALUE : r_quo[ACC_SIZE-1:0];

    // Iterate the restoring division, then register the saturated quotient and pulse done.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b0;
            r_fin      <= 1'b0;
            r_done     <= 1'b0;
            r_quotient <= '0;
        end else if (i_en) begin
            r_done <= 1'b0;
            if (i_start) begin
                r_divisor <= i_divisor;
                r_rem     <= '0;
                r_quo     <= '0;
                r_iter    <= '0;
                r_busy    <= 1'b1;
                r_fin     <= 1'b0;
            end else if (r_busy) begin
                r_rem  <= w_ge ? w_diff[CNT_WIDTH-1:0] : w_trial[CNT_WIDTH-1:0];
                r_quo  <= {r_quo[QW-2:0], w_ge};
                r_iter <= r_iter + IW'(1);
                if (r_iter == IW'(QW - 1)) begin
                    r_busy <= 1'b0;
                    r_fin  <= 1'b1;
                end
            end else if (r_fin) begin
                r_fin      <= 1'b0;
                r_done     <= 1'b1;
                r_quotient <= w_sat;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quotient;

endmodule

// File: rtl/nco_freq_meter.sv
// Rising-zero-crossing frequency meter: counts samples over 2^PERIODS_LOG2 tone periods and
// divides them back into the NCO step word that would regenerate the tone.
module nco_freq_meter
    import nco_pkg::*;
#(
    parameter int SAMPLE_WIDTH = nco_pkg::SAMPLE_WIDTH,
    parameter int ACC_SIZE     = nco_pkg::ACC_SIZE,
    parameter int PERIODS_LOG2 = nco_pkg::PERIODS_LOG2,
    parameter int CNT_WIDTH    = nco_pkg::CNT_WIDTH,
    parameter int HYST         = nco_pkg::HYST
) (
    input  logic            iclk,
    input  logic            ireset,
    nco_freq_meter_if.slave bus
);

    localparam int PW = PERIODS_LOG2 + 1;
    localparam logic [PW-1:0] PER_TARGET = PW'(1) << PERIODS_LOG2;
    localparam logic signed [SAMPLE_WIDTH-1:0] HYST_POS = SAMPLE_WIDTH'(HYST);
    localparam logic signed [SAMPLE_WIDTH-1:0] HYST_NEG = SAMPLE_WIDTH'(-HYST);

    meter_state_t         r_state;
    logic                 r_armed;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [PW-1:0]        r_per;
    logic                 r_timeout;
    logic                 r_busy;

    logic                 w_en;
    logic                 w_hi;
    logic                 w_lo;
    logic                 w_rise;
    logic                 w_cnt_max;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [PW-1:0]        w_per_next;
    logic                 w_term;
    logic                 w_div_busy;
    logic                 w_div_done;
    logic [ACC_SIZE-1:0]  w_quotient;

    assign w_en       = ~bus.inCS;
    assign w_hi       = (bus.sample >= HYST_POS);
    assign w_lo       = (bus.sample <= HYST_NEG);
    assign w_rise     = r_armed & w_hi;
    assign w_cnt_max  = &r_cnt;
    assign w_cnt_next = r_cnt + CNT_WIDTH'(1);
    assign w_per_next = r_per + PW'(1);
    // Counter overflow wins over a terminating crossing on the same cycle.
    assign w_term     = (r_state == MEASURE) & w_en & w_rise & ~w_cnt_max & (w_per_next == PER_TARGET);

    // Hysteresis: arm below -HYST, fire and disarm at or above +HYST.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_armed <= 1'b0;
        end else if (w_en) begin
            if (w_lo) begin
                r_armed <= 1'b1;
            end else if (w_rise) begin
                r_armed <= 1'b0;
            end
        end
    end

    // Measurement sequencer with registered timeout and busy flags.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_per     <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_en) begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_cnt   <= '0;
                        r_per   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_cnt_max) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_rise) begin
                            r_per <= w_per_next;
                            if (w_per_next == PER_TARGET) begin
                                r_state <= DIVIDE;
                            end
                        end
                    end
                end
                DIVIDE: begin
                    if (!w_div_busy) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    nco_step_divider #(
        .ACC_SIZE    (ACC_SIZE),
        .PERIODS_LOG2(PERIODS_LOG2),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_div (
        .iclk      (iclk),
        .ireset    (ireset),
        .i_en      (w_en),
        .i_start   (w_term),
        .i_divisor (w_cnt_next),
        .o_busy    (w_div_busy),
        .o_done    (w_div_done),
        .o_quotient(w_quotient)
    );

    assign bus.step_est = w_quotient;
    assign bus.valid    = w_div_done;
    assign bus.timeout  = r_timeout;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Directed bench for nco_freq_meter with a per-cycle behavioural model of the measurement.
module tb_nco_freq_meter;

    logic iclk   = 1'b0;
    logic ireset = 1'b1;
    int   n_err  = 0;
    int   n_chk  = 0;

    nco_freq_meter_if bus ();
    nco_freq_meter dut (.iclk(iclk), .ireset(ireset), .bus(bus));

    always #5 iclk = ~iclk;

    // Model state, advanced once per enabled sample.
    int ecnt = 0, m_mode = 0, m_n = 0, m_per = 0, m_due = 0, m_val = 0, m_term = 0;
    bit m_armed = 1'b0, e_valid = 1'b0, e_timeout = 1'b0, e_busy = 1'b0;
    int e_step = 0;
    // Events seen on the DUT outputs.
    int vcnt = 0, tcnt = 0, first_valid_idx = -1;
    bit prev_valid = 1'b0, prev_timeout = 1'b0, busy_seen = 1'b0;
    int s_idx = -1, phase = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int nco_smp(input int ph);
        real a;
        a = 6.283185307179586 * real'(ph) / 1024.0;
        return int'(30000.0 * $sin(a));
    endfunction

    // Mode 0 idle, 1 counting samples, 2 waiting for the divider result.
    task automatic model_step(input int smp);
        bit rise;
        ecnt++;
        rise      = m_armed && (smp >= 256);
        e_valid   = 1'b0;
        e_timeout = 1'b0;
        if (m_mode == 0) begin
            if (rise) begin
                m_mode = 1; m_n = 0; m_per = 0;
            end
        end else if (m_mode == 1) begin
            if (m_n == 65535) begin
                m_mode = 0; e_timeout = 1'b1;
            end else begin
                m_n++;
                if (rise) begin
                    m_per++;
                    if (m_per == 4) begin
                        m_mode = 2;
                        m_term = ecnt;
                        m_due  = ecnt + 14;
                        m_val  = 4096 / m_n;
                        if (m_val > 511) m_val = 511;
                    end
                end
            end
        end else if (ecnt == m_due) begin
            m_mode  = 0;
            e_valid = 1'b1;
            e_step  = m_val;
        end
        if (smp <= -256) m_armed = 1'b1;
        else if (rise) m_armed = 1'b0;
        e_busy = (m_mode != 0);
    endtask

    // Compare process: the inputs consumed at the last rising edge are still on the bus here.
    always @(negedge iclk) begin
        if (ireset) begin
            m_mode = 0; m_armed = 1'b0; e_valid = 1'b0; e_timeout = 1'b0; e_busy = 1'b0; e_step = 0;
        end else if (!bus.inCS) begin
            model_step(int'(bus.sample));
        end
        chk("outputs{valid,timeout,busy,step}",
            32'({bus.valid, bus.timeout, bus.busy, bus.step_est}),
            32'({e_valid, e_timeout, e_busy, 10'(e_step)}));
        if (bus.valid && !prev_valid) begin
            vcnt++;
            if (first_valid_idx < 0) first_valid_idx = s_idx;
        end
        if (bus.timeout && !prev_timeout) tcnt++;
        if (bus.busy) busy_seen = 1'b1;
        prev_valid   = bus.valid;
        prev_timeout = bus.timeout;
    end

    task automatic drive(input bit cs, input int smp);
        @(negedge iclk);
        #1;
        bus.inCS   = cs;
        bus.sample = 16'(smp);
    endtask

    task automatic nco_cycle(input int step, input bit dis);
        if (dis) begin
            drive(1'b1, int'($urandom_range(0, 65535)) - 32768);
        end else begin
            drive(1'b0, nco_smp(phase));
            phase = (phase + step) % 1024;
            s_idx++;
        end
    endtask

    task automatic run_nco(input int step, input int goal, input int maxc, input bit toggle);
        for (int i = 0; i < maxc && vcnt < goal; i++) nco_cycle(step, toggle && (i % 2 == 1));
        if (vcnt >= goal) bus.sample = '0;
        chk("valid_arrived", 32'(vcnt >= goal), 1);
    endtask

    initial begin
        int v0, t0;
        int pat[5] = '{-255, 255, -100, 100, 0};
        bus.inCS   = 1'b1;
        bus.sample = '0;
        repeat (2) @(negedge iclk);
        #1 ireset = 1'b0;

        // 1: step 64 loopback, two measurements
        phase = 0; s_idx = -1;
        run_nco(64, 2, 400, 1'b0);
        chk("s1_first_valid_sample_idx", first_valid_idx, 95);
        chk("s1_step_est", 32'(bus.step_est), 64);
        chk("s1_valid_count", vcnt, 2);

        // 3: activity inside the hysteresis band only
        busy_seen = 1'b0; v0 = vcnt; t0 = tcnt;
        repeat (20) drive(1'b0, 0);
        for (int i = 0; i < 100; i++) drive(1'b0, pat[i % 5]);
        chk("s3_no_valid", vcnt - v0, 0);
        chk("s3_no_timeout", tcnt - t0, 0);
        chk("s3_never_busy", 32'(busy_seen), 0);

        // 4: exact-threshold crossing, then the counter runs out
        v0 = vcnt; t0 = tcnt;
        drive(1'b0, -256);
        drive(1'b0, 256);
        repeat (65536) drive(1'b0, 1000);
        repeat (4) drive(1'b0, 0);
        chk("s4_timeout_once", tcnt - t0, 1);
        chk("s4_step_kept", 32'(bus.step_est), 64);
        chk("s4_idle", 32'(bus.busy), 0);
        chk("s4_no_valid", vcnt - v0, 0);

        // 2: step 100, fractional period
        phase = 0;
        for (int k = 0; k < 3; k++) begin
            run_nco(100, vcnt + 1, 400, 1'b0);
            chk("s2_step_in_99_102", 32'(bus.step_est >= 99 && bus.step_est <= 102), 1);
        end

        // 5: period-2 square wave saturates
        v0 = vcnt;
        for (int i = 0; i < 100 && vcnt < v0 + 1; i++) drive(1'b0, (i % 2 == 1) ? 2000 : -2000);
        bus.sample = '0;
        chk("s5_valid_arrived", 32'(vcnt > v0), 1);
        chk("s5_step_saturated", 32'(bus.step_est), 511);

        // 6: chip select toggling, then reset in the middle of a division
        phase = 0;
        run_nco(64, vcnt + 1, 600, 1'b1);
        chk("s6_step_est", 32'(bus.step_est), 64);
        for (int i = 0; i < 800 && !(m_mode == 2 && ecnt - m_term >= 5); i++) nco_cycle(64, i % 2 == 1);
        chk("s6_busy_in_divide", 32'(bus.busy), 1);
        @(negedge iclk);
        #2 ireset = 1'b1;
        #1 chk("s6_reset_clears", 32'({bus.valid, bus.timeout, bus.busy, bus.step_est}), 0);
        v0 = vcnt;
        repeat (3) @(negedge iclk);
        #1;
        ireset     = 1'b0;
        bus.inCS   = 1'b0;
        bus.sample = '0;
        repeat (40) drive(1'b0, 0);
        chk("s6_no_valid_after_reset", vcnt - v0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
